// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer for the MSP430 datapath: fetch, decode,
// operand fetch, execute and memory write-back with a bounded memory wait.
module exec_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] FORMAT,
  input  logic [2:0] AdAs,
  input  logic       BW,
  input  logic       NO_WB,
  input  logic       jump_take,
  input  logic       mem_rdy,
  output logic [1:0] MAB_SEL,
  output logic [2:0] MPC,
  output logic [1:0] MD,
  output logic       RW,
  output logic       MW,
  output logic       MEM_RD,
  output logic       IR_LD,
  output logic       EXT_LD,
  output logic       SRC_LD,
  output logic       DST_LD,
  output logic       SRC_INC,
  output logic       instr_done,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_SRC_EXT = 4'd3,
    S_SRC_RD  = 4'd4,
    S_DST_EXT = 4'd5,
    S_DST_RD  = 4'd6,
    S_EXEC    = 4'd7,
    S_WB_MEM  = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_st;
  logic          ad;
  logic [1:0]    as_m;
  logic          dst_mem;
  logic          reg_dst;
  logic          bw_unused;

  assign ad        = AdAs[2];
  assign as_m      = AdAs[1:0];
  assign dst_mem   = (FORMAT == 2'b00) && ad;
  assign reg_dst   = ((FORMAT == 2'b00) && !ad) || ((FORMAT == 2'b01) && (as_m == 2'b00));
  // Byte/word only scales the datapath's autoincrement step.
  assign bw_unused = BW;
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    mem_st     = 1'b0;
    MAB_SEL    = 2'b00;
    MPC        = 3'b000;
    MD         = 2'b00;
    RW         = 1'b0;
    MW         = 1'b0;
    MEM_RD     = 1'b0;
    IR_LD      = 1'b0;
    EXT_LD     = 1'b0;
    SRC_LD     = 1'b0;
    DST_LD     = 1'b0;
    SRC_INC    = 1'b0;
    instr_done = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      S_RESET: begin
        // Reset vector is only steered once rst has been released.
        if (rst) MPC = 3'b100;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_st = 1'b1;
        MEM_RD = 1'b1;
        if (mem_rdy) begin
          IR_LD   = 1'b1;
          MPC     = 3'b001;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (FORMAT == 2'b10)      state_d = S_EXEC;
        else if (FORMAT == 2'b11) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        else if (as_m == 2'b01)   state_d = S_SRC_EXT;
        else if (as_m[1])         state_d = S_SRC_RD;
        else if (dst_mem)         state_d = S_DST_EXT;
        else                      state_d = S_EXEC;
      end
      S_SRC_EXT, S_DST_EXT: begin
        mem_st = 1'b1;
        MEM_RD = 1'b1;
        if (mem_rdy) begin
          EXT_LD  = 1'b1;
          MPC     = 3'b001;
          state_d = (state_q == S_SRC_EXT) ? S_SRC_RD : S_DST_RD;
        end
      end
      S_SRC_RD: begin
        mem_st  = 1'b1;
        MEM_RD  = 1'b1;
        MAB_SEL = (as_m == 2'b01) ? 2'b11 : 2'b01;
        if (mem_rdy) begin
          SRC_LD  = 1'b1;
          SRC_INC = (as_m == 2'b11);
          state_d = dst_mem ? S_DST_EXT : S_EXEC;
        end
      end
      S_DST_RD: begin
        mem_st  = 1'b1;
        MEM_RD  = 1'b1;
        MAB_SEL = 2'b11;
        if (mem_rdy) begin
          DST_LD  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (FORMAT == 2'b10) begin
          MPC        = jump_take ? 3'b010 : 3'b000;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (reg_dst) begin
          RW         = !NO_WB;
          MD         = 2'b00;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (NO_WB) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        mem_st  = 1'b1;
        MAB_SEL = 2'b11;
        MW      = 1'b1;
        if (mem_rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Stalled memory access: hold, count, abort once the budget is spent.
    if (mem_st && !mem_rdy) begin
      if (cnt_q == CW'(WAIT_MAX - 1)) begin
        bus_err = 1'b1;
        state_d = S_FETCH;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle control FSM for the MSP430 datapath. It steps each instruction through fetch, decode, operand fetch, execute and memory write-back. It drives the MAB mux select, PC mux select, register-Din mux select, register/memory write strobes and operand-latch strobes, based on instr_dec fields and a memory-ready handshake. It replaces direct instr_dec control of MAB_SEL/MPC/MD/RW at pipeline level.

Parameters:
WAIT_MAX, 15, memory-wait cycles tolerated before bus-error abort (1..255)
CW, 8, width of wait counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
FORMAT  input  2  00 double-op, 01 single-op, 10 jump, 11 illegal
AdAs  input  3  [2]=Ad, [1:0]=As
BW  input  1  byte op (1) / word op (0)
NO_WB  input  1  result discarded (CMP/BIT-class)
jump_take  input  1  jump condition true (valid in EXEC)
mem_rdy  input  1  memory access completes this cycle
MAB_SEL  output  2  00 PC, 01 Sout, 10 Dout, 11 CALC_OUT
MPC  output  3  000 hold, 001 PC+2, 010 CALC_OUT, 011 MDB_out, 100 RST_VEC
MD  output  2  00 F_OUT, 01 MDB_out, 10 Sout
RW  output  1  register-file write
MW  output  1  memory write
MEM_RD  output  1  memory read request
IR_LD  output  1  load instruction register
EXT_LD  output  1  load extension-word latch
SRC_LD  output  1  load source-operand latch
DST_LD  output  1  load destination-operand latch
SRC_INC  output  1  autoincrement Rs (by 1 if BW, else 2)
instr_done  output  1  one-cycle pulse at instruction retire
bus_err  output  1  one-cycle pulse on wait timeout
state_o  output  4  current state code

Behaviour:
- rst low (async): state RESET (0). Wait counter 0. All outputs 0, including MPC=000 and MAB_SEL=00.
- State codes: RESET 0, FETCH 1, DECODE 2, SRC_EXT 3, SRC_RD 4, DST_EXT 5, DST_RD 6, EXEC 7, WB_MEM 8. Codes 9-15 are illegal and go to FETCH.
- Outputs are Moore on state, plus mem_rdy/FORMAT/AdAs/NO_WB/jump_take qualification. Unlisted outputs are 0.
- RESET: first cycle after rst release asserts MPC=100, then goes to FETCH.
- FETCH: MAB_SEL=00, MEM_RD=1. On mem_rdy: IR_LD=1, MPC=001, go to DECODE.
- DECODE: one cycle, no strobes. Next state:
  - FORMAT=10 -> EXEC.
  - FORMAT=11 -> FETCH with instr_done=1 (illegal = NOP).
  - As=01 -> SRC_EXT.
  - As=10/11 -> SRC_RD.
  - As=00 and FORMAT=00 and Ad=1 -> DST_EXT.
  - Otherwise -> EXEC.
- SRC_EXT: MAB_SEL=00, MEM_RD=1. On mem_rdy: EXT_LD=1, MPC=001, go to SRC_RD.
- SRC_RD: MAB_SEL=11 if As=01, else 01. MEM_RD=1. On mem_rdy: SRC_LD=1; SRC_INC=1 if As=11. Next: DST_EXT if FORMAT=00 and Ad=1, else EXEC.
- DST_EXT: same as SRC_EXT, going to DST_RD.
- DST_RD: MAB_SEL=11, MEM_RD=1. On mem_rdy: DST_LD=1, go to EXEC.
- EXEC, by case:
  - Jump: MPC=010 if jump_take else 000; instr_done=1; go to FETCH.
  - Register destination (FORMAT=00 with Ad=0, or FORMAT=01 with As=00): RW=!NO_WB, MD=00, instr_done=1, go to FETCH.
  - Memory destination with NO_WB=1: instr_done=1, go to FETCH.
  - Memory destination otherwise: go to WB_MEM.
- WB_MEM: MAB_SEL=11 (address held by datapath), MW=1. On mem_rdy: instr_done=1, go to FETCH.
- Memory wait:
  - In memory states with mem_rdy=0: state holds, MEM_RD/MW/MAB_SEL held, all load/inc/PC strobes 0, counter increments.
  - Counter clears on every state change.
  - Counter reaching WAIT_MAX with mem_rdy still 0: bus_err=1 for one cycle, instruction aborted (no RW/MW/PC update), go to FETCH.
  - mem_rdy=1 in the timeout cycle wins; no bus_err.
- Byte/word: BW only affects the SRC_INC size seen by the datapath; the FSM path is identical.
- rst assertion in any state, including mid-wait, aborts immediately. No partial writes are issued after rst falls.

Test Plan:
- Reset: rst=0 then 1 -> outputs 0 while low; 1st cycle after release MPC=100; 2nd cycle state_o=1, MAB_SEL=00, MEM_RD=1.
- Register MOV (FORMAT=00, AdAs=000, NO_WB=0, mem_rdy=1) -> states 1,2,7. RW=1 and MD=00 in EXEC; instr_done after 3 cycles.
- Indexed-to-indexed ADD (AdAs=101) -> states 1,2,3,4,5,6,7,8. EXT_LD in states 3 and 5, MPC=001 in 1/3/5, MW=1 in 8; instr_done at cycle 8.
- Autoincrement single-op (FORMAT=01, As=11) -> states 1,2,4,7,8. SRC_INC=1 in state 4; no RW; MW in state 8.
- Jump with jump_take=1 -> states 1,2,7, MPC=010 in EXEC. Repeat with jump_take=0 -> MPC=000.
- mem_rdy held 0 in FETCH with WAIT_MAX=3 -> state stays 1 for 3 cycles; bus_err pulse; IR_LD never 1; re-enters FETCH. A second run with mem_rdy=1 on wait cycle 2 -> no bus_err.
